button_debouncer: RTL and testbench
===================================

# button_debouncer

Debounces one raw, asynchronous pushbutton input and produces a clean level plus single-cycle press, release and optional long-press pulses. The block sits between the board pushbutton pin and the edge-detect / pulse-stretch stage. That stage consumes `btn_level` or `press_pulse`, so it never sees contact bounce. The clock is 125 MHz; the defaults give a 10 ms debounce window and a 1 s long press.

## Interface
- `DEBOUNCE_CYCLES`, default 1250000: cycles the synchronized input must be stable before a change is accepted; minimum 2.
- `LONG_PRESS_CYCLES`, default 125000000: cycles `btn_level` must stay high before `long_press_pulse` fires; minimum 2.
- `CNT_W`, default 27: counter width; must hold max(`DEBOUNCE_CYCLES`, `LONG_PRESS_CYCLES`).
- `clk` input 1: clock; all logic on rising edge.
- `reset` input 1: reset, asynchronous, active-high.
- `btn_in` input 1: raw button; asynchronous, bouncing, active-high.
- `btn_level` output 1: debounced button state.
- `press_pulse` output 1: one-cycle pulse on accepted press.
- `release_pulse` output 1: one-cycle pulse on accepted release.
- `long_press_pulse` output 1: one-cycle pulse when a press has been held `LONG_PRESS_CYCLES`.

## Operation
- `btn_in` passes through a 2-flop synchronizer to give `sync`; the FSM reads only `sync`.
- FSM states and transitions:
  - IDLE: `btn_level`=0. If `sync`=1, go to ARM_PRESS and clear the debounce counter.
  - ARM_PRESS: if `sync`=0, return to IDLE (bounce rejected) and clear the counter. Else increment. At counter==`DEBOUNCE_CYCLES`-1 with `sync`=1, go to PRESSED, set `btn_level`=1, pulse `press_pulse`, clear the long counter.
  - PRESSED: if `sync`=0, go to ARM_RELEASE and clear the debounce counter.
  - ARM_RELEASE: if `sync`=1, return to PRESSED. Else increment. At counter==`DEBOUNCE_CYCLES`-1 with `sync`=0, go to IDLE, set `btn_level`=0, pulse `release_pulse`.
- Long counter:
  - Runs in PRESSED and ARM_RELEASE.
  - Holds its value during a release bounce; it is not cleared by returning to PRESSED.
  - Fires `long_press_pulse` once on reaching `LONG_PRESS_CYCLES`-1, then saturates (no repeat).
  - Cleared on entry to PRESSED from ARM_PRESS.
- All outputs are registered. `press_pulse`, `release_pulse` and `long_press_pulse` are mutually exclusive in any cycle.
- Reset mid-operation: state IDLE; counters, synchronizer and all outputs 0.
  - A button held through reset deassertion is treated as a new press: `press_pulse` fires after the full latency.

## Timing
- Reset values: `btn_level`=0, `press_pulse`=0, `release_pulse`=0, `long_press_pulse`=0.
- Press latency: with `btn_in` first sampled high at edge 0 and held, ARM_PRESS is entered at edge 2. `btn_level` rises and `press_pulse` is high for exactly one cycle after edge `DEBOUNCE_CYCLES`+2.
- Release latency: identical, `DEBOUNCE_CYCLES`+2 edges.
- Long press: `long_press_pulse` follows `LONG_PRESS_CYCLES` edges after the `press_pulse` edge, assuming no release bounce.
- Any `sync` glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- Counter compare is equality on `CNT_W`-bit unsigned values; counters never wrap.

## Configuration
- `BUTTON_DEBOUNCER_LONG_PRESS_EN` defined: long counter and `long_press_pulse` logic are present as described.
- Undefined: the long counter is not built, `long_press_pulse` is tied 0, and `LONG_PRESS_CYCLES` is ignored. All other behaviour is identical.

## Structure
- Shared package `button_pkg`:
  - FSM state typedef: IDLE, ARM_PRESS, PRESSED, ARM_RELEASE.
  - Default cycle constants for 125 MHz: 10 ms and 1 s.
- Sub-module `sync_2ff`: a 2-flop synchronizer with asynchronous reset to 0, instantiated once for `btn_in`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `LONG_PRESS_CYCLES`=20.
- Clean press: `btn_in` 0→1 before edge 0, held → `btn_level`=1 and `press_pulse`=1 for one cycle after edge 6 only.
- Bounce reject: `btn_in` high for 3 cycles, low for 2, then held high → no pulse during the bounce; `press_pulse` fires 6 edges after the final rise.
- Clean release after a settled press: `btn_in` 1→0 held → `release_pulse` for one cycle 6 edges later, `btn_level`=0. A 2-cycle low glitch instead produces nothing.
- Long press with macro defined: hold 40 cycles → exactly one `long_press_pulse`, 20 edges after `press_pulse`. With the macro undefined, it stays 0.
- Reset mid-ARM_PRESS, `btn_in` held high:
  - All outputs read 0 during reset.
  - After deassertion, `press_pulse` fires 6 edges after the first sampling edge.

Source files
------------

// File: rtl/button_pkg.sv
// Shared types and 125 MHz default timing constants for the pushbutton debouncer.
package button_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARM_PRESS,
    PRESSED,
    ARM_RELEASE
  } btn_state_e;

  // 10 ms and 1 s at 125 MHz; 27 bits covers the larger of the two.
  localparam int DEF_DEBOUNCE_CYCLES   = 1250000;
  localparam int DEF_LONG_PRESS_CYCLES = 125000000;
  localparam int DEF_CNT_W             = 27;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Pushbutton debouncer: clean level plus press/release/long-press pulses.
// Long-press logic is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
  parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES,
  parameter int CNT_W             = DEF_CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press_pulse
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync;
  btn_state_e       state, state_nxt;
  logic [CNT_W-1:0] db_cnt, db_cnt_nxt;
  logic             level_nxt, press_nxt, release_nxt;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (sync)
  );

  always_comb begin
    state_nxt   = state;
    db_cnt_nxt  = db_cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_nxt  = ARM_PRESS;
          db_cnt_nxt = '0;
        end
      end
      ARM_PRESS: begin
        if (!sync) begin
          state_nxt  = IDLE;
          db_cnt_nxt = '0;
        end else if (db_cnt == DB_LAST) begin
          state_nxt = PRESSED;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!sync) begin
          state_nxt  = ARM_RELEASE;
          db_cnt_nxt = '0;
        end
      end
      ARM_RELEASE: begin
        if (sync) begin
          state_nxt = PRESSED;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      db_cnt        <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_nxt;
      db_cnt        <= db_cnt_nxt;
      btn_level     <= level_nxt;
      press_pulse   <= press_nxt;
      release_pulse <= release_nxt;
    end
  end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);

  logic [CNT_W-1:0] long_cnt, long_cnt_nxt;
  logic             long_nxt;

  // Counter parks one past LP_LAST so the pulse cannot repeat; a release
  // accepted on the same edge wins to keep the pulses exclusive.
  always_comb begin
    long_cnt_nxt = long_cnt;
    long_nxt     = 1'b0;
    if (press_nxt) begin
      long_cnt_nxt = '0;
    end else if (state == PRESSED || state == ARM_RELEASE) begin
      if (long_cnt == LP_LAST) begin
        long_cnt_nxt = long_cnt + CNT_W'(1);
        long_nxt     = !release_nxt;
      end else if (long_cnt < LP_LAST) begin
        long_cnt_nxt = long_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      long_cnt         <= '0;
      long_press_pulse <= 1'b0;
    end else begin
      long_cnt         <= long_cnt_nxt;
      long_press_pulse <= long_nxt;
    end
  end
`else
  logic unused_long_cfg;
  assign unused_long_cfg  = ^LONG_PRESS_CYCLES;
  assign long_press_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with a run-length reference model.
module tb_button_debouncer;

  localparam int DB = 4;
  localparam int LP = 20;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, btn_in;
  logic btn_level, press_pulse, release_pulse, long_press_pulse;

  int pass_cnt  = 0;
  int total_cnt = 0;

  button_debouncer #(
    .DEBOUNCE_CYCLES   (DB),
    .LONG_PRESS_CYCLES (LP),
    .CNT_W             (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .btn_in           (btn_in),
    .btn_level        (btn_level),
    .press_pulse      (press_pulse),
    .release_pulse    (release_pulse),
    .long_press_pulse (long_press_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %b want %b at %0t", name, act, exp, $time);
  endtask

  // Reference: the FSM sees btn_in two samples late; the level flips once
  // DB+1 consecutive samples disagree with it. Long press fires on the LP-th
  // edge spent high after the press edge, unless that edge is a release.
  bit s1, s2, m_lvl, m_seen, m_flip;
  int m_run, m_held;
  bit e_press, e_rel, e_long;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 = 0; s2 = 0; m_lvl = 0; m_run = 0; m_held = 0;
      e_press = 0; e_rel = 0; e_long = 0;
    end else begin
      e_press = 0; e_rel = 0; e_long = 0;
      m_seen  = s2;
      m_run   = (m_seen != m_lvl) ? m_run + 1 : 0;
      m_flip  = (m_run == DB + 1);
      if (m_lvl) m_held++;
      if (m_flip) begin
        m_run = 0;
        if (m_lvl) e_rel = 1;
        else begin
          e_press = 1;
          m_held  = 0;
        end
        m_lvl = !m_lvl;
      end else if (m_lvl && m_held == LP) begin
        e_long = LP_EN;
      end
      s2 = s1;
      s1 = btn_in;
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_level",   btn_level,        m_lvl);
    chk("model_press",   press_pulse,      e_press);
    chk("model_release", release_pulse,    e_rel);
    chk("model_long",    long_press_pulse, e_long);
    chk("pulse_excl", (int'(press_pulse) + int'(release_pulse) + int'(long_press_pulse)) <= 1, 1'b1);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v);
    @(negedge clk);
    btn_in = v;
  endtask

  initial begin
    reset  = 1'b1;
    btn_in = 1'b0;
    edges(3);
    chk("rst_level",   btn_level,        1'b0);
    chk("rst_press",   press_pulse,      1'b0);
    chk("rst_release", release_pulse,    1'b0);
    chk("rst_long",    long_press_pulse, 1'b0);
    @(negedge clk) reset = 1'b0;
    edges(4);

    // Clean press, held long enough for the long-press pulse
    drive(1'b1);
    edges(6);
    chk("press_e5", press_pulse, 1'b0);
    chk("level_e5", btn_level,   1'b0);
    edges(1);
    chk("press_e6", press_pulse, 1'b1);
    chk("level_e6", btn_level,   1'b1);
    edges(1);
    chk("press_e7", press_pulse, 1'b0);
    edges(18);
    chk("long_e25", long_press_pulse, 1'b0);
    edges(1);
    chk("long_e26", long_press_pulse, LP_EN);
    edges(1);
    chk("long_e27", long_press_pulse, 1'b0);
    edges(20);

    // Two-cycle low glitch is ignored
    drive(1'b0);
    drive(1'b0);
    drive(1'b1);
    edges(12);
    chk("glitch_level", btn_level, 1'b1);

    // Clean release
    drive(1'b0);
    edges(6);
    chk("rel_e5", release_pulse, 1'b0);
    edges(1);
    chk("rel_e6",       release_pulse, 1'b1);
    chk("rel_level_e6", btn_level,     1'b0);
    edges(1);
    chk("rel_e7", release_pulse, 1'b0);
    edges(4);

    // Bounce: high 3, low 2, then held high
    drive(1'b1); drive(1'b1); drive(1'b1);
    drive(1'b0); drive(1'b0);
    drive(1'b1);
    edges(6);
    chk("bounce_e5",       press_pulse, 1'b0);
    chk("bounce_level_e5", btn_level,   1'b0);
    edges(1);
    chk("bounce_e6", press_pulse, 1'b1);
    edges(4);
    drive(1'b0);
    edges(10);

    // Reset while arming a press, button held through reset
    drive(1'b1);
    edges(4);
    @(negedge clk) reset = 1'b1;
    #1;
    chk("midrst_level",   btn_level,        1'b0);
    chk("midrst_press",   press_pulse,      1'b0);
    chk("midrst_release", release_pulse,    1'b0);
    chk("midrst_long",    long_press_pulse, 1'b0);
    edges(2);
    chk("midrst_level2", btn_level, 1'b0);
    @(negedge clk) reset = 1'b0;
    edges(6);
    chk("postrst_e5", press_pulse, 1'b0);
    edges(1);
    chk("postrst_e6",    press_pulse, 1'b1);
    chk("postrst_level", btn_level,   1'b1);
    edges(3);
    drive(1'b0);
    edges(8);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
